// File: rtl/output_port_lookup_pkg.sv
// Shared constants, header layout and destination computation for the
// output port lookup stage.
package output_port_lookup_pkg;

   // ctrl value that tags the IO-queue module header word
   localparam logic [7:0] IOQ_STAGE_NUM = 8'hFF;

   // MAC ports sit on the even destination bits, CPU ports on the odd bits
   localparam logic [15:0] MAC_MASK = 16'h0055;

   // IO-queue header layout, most significant field first:
   // dst 63:48, word_len 47:32, src 31:16, byte_len 15:0
   typedef struct packed {
      logic [15:0] dst;
      logic [15:0] word_len;
      logic [15:0] src;
      logic [15:0] byte_len;
   } ioq_hdr_t;

   // Even source (MAC) port: flood to every other MAC port.
   // Odd source (CPU) port: send to the MAC port paired with it.
   // Anything beyond the port range yields an empty destination.
   function automatic logic [15:0] calc_dst(input logic [15:0] src, input int num_q);
      logic [15:0] dst;
      logic [15:0] q_mask;
      dst    = 16'h0000;
      q_mask = 16'((32'd1 << num_q) - 32'd1);
      if (src < 16'(num_q)) begin
         if (src[0])
            dst = 16'd1 << (src[3:0] - 4'd1);
         else
            dst = MAC_MASK & ~(16'd1 << src[3:0]);
      end
      return dst & q_mask;
   endfunction

endpackage

// File: rtl/output_port_lookup_if.sv
// Word bus with write strobe and back-pressure used on both sides of the
// output port lookup stage.
interface output_port_lookup_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH/8
);
   logic [DATA_WIDTH-1:0] data;
   logic [CTRL_WIDTH-1:0] ctrl;
   logic                  wr;
   logic                  rdy;

   // sender drives the word and strobe, receiver answers with rdy
   modport master (output data, output ctrl, output wr, input rdy);
   modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/small_fifo.sv
// Small show-ahead FIFO: dout always presents the oldest entry, a read
// simply advances past it. Writes while full are dropped.
module small_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             empty
);
   localparam int DEPTH = 2**MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] FULL_LVL = (MAX_DEPTH_BITS+1)'(DEPTH);
   localparam logic [MAX_DEPTH_BITS:0] NF_LVL   = (MAX_DEPTH_BITS+1)'(DEPTH-1);

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [MAX_DEPTH_BITS:0]   depth;
   logic                      wr_ok;
   logic                      rd_ok;

   assign wr_ok       = wr_en && !full;
   assign rd_ok       = rd_en && !empty;
   assign dout        = mem[rd_ptr];
   assign full        = (depth == FULL_LVL);
   assign nearly_full = (depth >= NF_LVL);
   assign empty       = (depth == '0);

   // storage array, contents need no reset
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= din;
   end

   // pointers and fill level
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         depth  <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok)
            rd_ptr <= rd_ptr + 1'b1;
         depth <= depth + (MAX_DEPTH_BITS+1)'(wr_ok) - (MAX_DEPTH_BITS+1)'(rd_ok);
      end
   end

endmodule

// File: rtl/output_port_lookup.sv
// Output port lookup: buffers arbiter words, rewrites the destination field
// of the IO-queue header from the source port, and counts forwarded and
// undeliverable packets.
module output_port_lookup #(
   parameter int         DATA_WIDTH        = 64,
   parameter int         CTRL_WIDTH        = DATA_WIDTH/8,
   parameter logic [7:0] IOQ_STAGE_NUM     = output_port_lookup_pkg::IOQ_STAGE_NUM,
   parameter int         NUM_OUTPUT_QUEUES = 8
)(
   input  logic                  clk,
   input  logic                  reset,
   output_port_lookup_if.slave   up,
   output_port_lookup_if.master  down,
   output logic [31:0]           pkt_count,
   output logic [31:0]           drop_count
);
   import output_port_lookup_pkg::*;

   localparam logic [0:0] MOD_HDRS  = 1'b0;
   localparam logic [0:0] IN_PACKET = 1'b1;

   logic [0:0]                       state;
   logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout;
   logic [DATA_WIDTH-1:0]            word_data;
   logic [CTRL_WIDTH-1:0]            word_ctrl;
   logic                             fifo_empty;
   logic                             fifo_full;
   logic                             fifo_nf;
   logic                             rd;
   logic                             is_ioq;
   logic [15:0]                      dst;
   ioq_hdr_t                         hdr_in;
   ioq_hdr_t                         hdr_out;
   logic [DATA_WIDTH-1:0]            mod_data;

   small_fifo #(
      .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
      .MAX_DEPTH_BITS (2)
   ) in_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({up.ctrl, up.data}),
      .wr_en       (up.wr && !fifo_full),
      .rd_en       (rd),
      .dout        (fifo_dout),
      .full        (fifo_full),
      .nearly_full (fifo_nf),
      .empty       (fifo_empty)
   );

   // one slot of headroom is kept so a word already in flight still fits
   assign up.rdy    = !fifo_nf;
   assign rd        = !fifo_empty && down.rdy;
   assign word_ctrl = fifo_dout[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH];
   assign word_data = fifo_dout[DATA_WIDTH-1:0];

   // destination rewrite for the IO-queue header at the FIFO head
   always_comb begin
      hdr_in   = ioq_hdr_t'(word_data[63:0]);
      dst      = calc_dst(hdr_in.src, NUM_OUTPUT_QUEUES);
      is_ioq   = (state == MOD_HDRS) && (word_ctrl == CTRL_WIDTH'(IOQ_STAGE_NUM));
      hdr_out  = hdr_in;
      hdr_out.dst = dst;
      mod_data = word_data;
      if (is_ioq)
         mod_data[63:0] = hdr_out;
   end

   // output register, packet framing FSM and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= MOD_HDRS;
         down.wr    <= 1'b0;
         down.data  <= '0;
         down.ctrl  <= '0;
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         down.wr <= rd;
         if (rd) begin
            down.data <= mod_data;
            down.ctrl <= word_ctrl;
            case (state)
               MOD_HDRS: begin
                  if (is_ioq && (dst == 16'h0000))
                     drop_count <= drop_count + 32'd1;
                  if (word_ctrl == '0)
                     state <= IN_PACKET;
               end
               default: begin
                  if (word_ctrl != '0) begin
                     pkt_count <= pkt_count + 32'd1;
                     state     <= MOD_HDRS;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_output_port_lookup.sv
// Directed bench for output_port_lookup: table of packet words with
// hand-computed expected output words, plus stall, reset and wrap sequences.
module tb_output_port_lookup;

   typedef struct {
      logic [7:0]  ctrl;
      logic [63:0] din;
      logic [63:0] dexp;
   } vec_t;

   typedef struct {
      logic [7:0]  ctrl;
      logic [63:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pkt_count;
   logic [31:0] drop_count;

   vec_t  vecs[$];
   word_t got[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   logic  stall_rdy;

   output_port_lookup_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) up_if ();
   output_port_lookup_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dn_if ();

   output_port_lookup #(
      .DATA_WIDTH        (64),
      .CTRL_WIDTH        (8),
      .IOQ_STAGE_NUM     (8'hFF),
      .NUM_OUTPUT_QUEUES (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .up         (up_if),
      .down       (dn_if),
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   // capture every word the DUT writes, sampled on the falling edge
   always @(negedge clk) begin
      if (dn_if.wr === 1'b1)
         got.push_back('{ctrl: dn_if.ctrl, data: dn_if.data});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] hdr(input logic [15:0] dst, input logic [15:0] src);
      return {dst, 16'h0003, src, 16'h0018};
   endfunction

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] c, input logic [63:0] din, input logic [63:0] dexp);
      vecs.push_back('{ctrl: c, din: din, dexp: dexp});
   endtask

   // called at a falling edge; waits (bounded) for in_rdy then writes one word
   task automatic send_word(input logic [7:0] c, input logic [63:0] d);
      int t = 0;
      while (up_if.rdy !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (up_if.rdy !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_word: in_rdy stuck at %b, required 1", up_if.rdy);
      end
      up_if.ctrl = c;
      up_if.data = d;
      up_if.wr   = 1'b1;
      @(negedge clk);
      up_if.wr   = 1'b0;
   endtask

   task automatic send_all();
      for (int i = 0; i < vecs.size(); i++)
         send_word(vecs[i].ctrl, vecs[i].din);
   endtask

   task automatic wait_words(input int n);
      int t = 0;
      while (got.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      check("word_count", 72'(got.size()), 72'(n));
   endtask

   task automatic compare_words(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         if (i < got.size())
            check($sformatf("%s_word%0d", tag, i), {got[i].ctrl, got[i].data},
                  {vecs[i].ctrl, vecs[i].dexp});
         else
            check($sformatf("%s_word%0d", tag, i), 72'bx, {vecs[i].ctrl, vecs[i].dexp});
      end
   endtask

   initial begin
      reset       = 1'b1;
      up_if.data  = '0;
      up_if.ctrl  = '0;
      up_if.wr    = 1'b0;
      dn_if.rdy   = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset state
      check("rst_out_wr",   72'(dn_if.wr),   72'd0);
      check("rst_out_ctrl", 72'(dn_if.ctrl), 72'd0);
      check("rst_out_data", 72'(dn_if.data), 72'd0);
      check("rst_pkt",      72'(pkt_count),  72'd0);
      check("rst_drop",     72'(drop_count), 72'd0);
      check("rst_in_rdy",   72'(up_if.rdy),  72'd1);

      // table: back-to-back packets, out_rdy held high
      add(8'hFF, hdr(16'hBEEF, 16'h0002), hdr(16'h0051, 16'h0002));
      add(8'h00, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);
      add(8'h80, 64'hAAAA_BBBB_CCCC_DDDD, 64'hAAAA_BBBB_CCCC_DDDD);
      add(8'hFF, hdr(16'h1234, 16'h0003), hdr(16'h0004, 16'h0003));
      add(8'h00, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101);
      add(8'h00, 64'h0202_0202_0202_0202, 64'h0202_0202_0202_0202);
      add(8'h80, 64'h0303_0303_0303_0303, 64'h0303_0303_0303_0303);
      add(8'hFF, hdr(16'hFFFF, 16'h0009), hdr(16'h0000, 16'h0009));
      add(8'h00, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555);
      add(8'h80, 64'h6666_6666_6666_6666, 64'h6666_6666_6666_6666);
      add(8'h40, 64'hCAFE_0000_0002_0000, 64'hCAFE_0000_0002_0000);
      add(8'hFF, hdr(16'h0000, 16'h0000), hdr(16'h0054, 16'h0000));
      add(8'h00, 64'h7777_7777_7777_7777, 64'h7777_7777_7777_7777);
      add(8'h01, 64'h8888_8888_8888_8888, 64'h8888_8888_8888_8888);
      add(8'h40, 64'hF00D_0000_0003_0000, 64'hF00D_0000_0003_0000);
      add(8'hFF, hdr(16'hAAAA, 16'h0007), hdr(16'h0040, 16'h0007));
      add(8'h00, 64'h9999_9999_9999_9999, 64'h9999_9999_9999_9999);
      add(8'h80, 64'h1212_1212_1212_1212, 64'h1212_1212_1212_1212);
      add(8'h40, 64'hFFFF_FFFF_0002_FFFF, 64'hFFFF_FFFF_0002_FFFF);
      add(8'h00, 64'h3434_3434_3434_3434, 64'h3434_3434_3434_3434);
      add(8'h80, 64'h5656_5656_5656_5656, 64'h5656_5656_5656_5656);
      add(8'hFF, hdr(16'h0F0F, 16'h0006), hdr(16'h0015, 16'h0006));
      add(8'h00, 64'h7878_7878_7878_7878, 64'h7878_7878_7878_7878);
      add(8'h80, 64'h9A9A_9A9A_9A9A_9A9A, 64'h9A9A_9A9A_9A9A_9A9A);
      add(8'hFF, hdr(16'h0000, 16'h0005), hdr(16'h0010, 16'h0005));
      add(8'h00, 64'hBCBC_BCBC_BCBC_BCBC, 64'hBCBC_BCBC_BCBC_BCBC);
      add(8'h80, 64'hDEDE_DEDE_DEDE_DEDE, 64'hDEDE_DEDE_DEDE_DEDE);
      add(8'hFF, hdr(16'h9999, 16'h0004), hdr(16'h0045, 16'h0004));
      add(8'h00, 64'h0000_0000_0002_0000, 64'h0000_0000_0002_0000);
      add(8'hFF, 64'h1234_5678_0002_0000, 64'h1234_5678_0002_0000);
      send_all();
      wait_words(30);
      compare_words("tbl");
      check("tbl_pkt",    72'(pkt_count),  72'd9);
      check("tbl_drop",   72'(drop_count), 72'd1);
      check("tbl_in_rdy", 72'(up_if.rdy),  72'd1);

      // out_rdy low for 5 cycles mid-packet while the source keeps writing
      vecs.delete();
      got.delete();
      add(8'hFF, hdr(16'h0000, 16'h0005), hdr(16'h0010, 16'h0005));
      add(8'h00, 64'hA1A1_A1A1_A1A1_A1A1, 64'hA1A1_A1A1_A1A1_A1A1);
      add(8'h00, 64'hA2A2_A2A2_A2A2_A2A2, 64'hA2A2_A2A2_A2A2_A2A2);
      add(8'h00, 64'hA3A3_A3A3_A3A3_A3A3, 64'hA3A3_A3A3_A3A3_A3A3);
      add(8'h00, 64'hA4A4_A4A4_A4A4_A4A4, 64'hA4A4_A4A4_A4A4_A4A4);
      add(8'h80, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5);
      stall_rdy = 1'bx;
      fork
         send_all();
         begin
            repeat (2) @(negedge clk);
            dn_if.rdy = 1'b0;
            repeat (5) @(negedge clk);
            stall_rdy = up_if.rdy;
            dn_if.rdy = 1'b1;
         end
      join
      check("stall_in_rdy_low", 72'(stall_rdy), 72'd0);
      wait_words(6);
      compare_words("stall");
      check("stall_pkt",    72'(pkt_count), 72'd10);
      check("stall_in_rdy", 72'(up_if.rdy), 72'd1);

      // reset while the second payload word is being written
      got.delete();
      send_word(8'hFF, hdr(16'h0000, 16'h0002));
      send_word(8'h00, 64'hB1B1_B1B1_B1B1_B1B1);
      up_if.ctrl = 8'h00;
      up_if.data = 64'hB2B2_B2B2_B2B2_B2B2;
      up_if.wr   = 1'b1;
      reset      = 1'b1;
      @(negedge clk);
      up_if.wr   = 1'b0;
      check("mid_rst_out_wr",   72'(dn_if.wr),   72'd0);
      check("mid_rst_out_data", 72'(dn_if.data), 72'd0);
      check("mid_rst_out_ctrl", 72'(dn_if.ctrl), 72'd0);
      check("mid_rst_pkt",      72'(pkt_count),  72'd0);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_in_rdy", 72'(up_if.rdy), 72'd1);
      got.delete();
      vecs.delete();
      add(8'hFF, hdr(16'h4321, 16'h0001), hdr(16'h0001, 16'h0001));
      add(8'h00, 64'hC1C1_C1C1_C1C1_C1C1, 64'hC1C1_C1C1_C1C1_C1C1);
      add(8'h80, 64'hC2C2_C2C2_C2C2_C2C2, 64'hC2C2_C2C2_C2C2_C2C2);
      send_all();
      wait_words(3);
      compare_words("post_rst");
      check("post_rst_pkt",  72'(pkt_count),  72'd1);
      check("post_rst_drop", 72'(drop_count), 72'd0);

      // packet counter wraps from all-ones to zero
      force dut.pkt_count = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.pkt_count;
      got.delete();
      vecs.delete();
      add(8'hFF, hdr(16'h0000, 16'h0009), hdr(16'h0000, 16'h0009));
      add(8'h00, 64'hD1D1_D1D1_D1D1_D1D1, 64'hD1D1_D1D1_D1D1_D1D1);
      add(8'h80, 64'hD2D2_D2D2_D2D2_D2D2, 64'hD2D2_D2D2_D2D2_D2D2);
      send_all();
      wait_words(3);
      compare_words("wrap");
      check("wrap_pkt",  72'(pkt_count),  72'd0);
      check("wrap_drop", 72'(drop_count), 72'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/output_port_lookup.md
OUTPUT_PORT_LOOKUP -- requirements
Module: output_port_lookup

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64: datapath word width.
REQ-002 The block SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8: control byte width.
REQ-003 The block SHALL have parameter IOQ_STAGE_NUM, default 8'hFF: ctrl value marking the IO-queue module header.
REQ-004 The block SHALL have parameter NUM_OUTPUT_QUEUES, default 8: number of one-hot destination bits used (MAC ports on even bits, CPU ports on odd bits).
REQ-005 Ports SHALL be:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- in_data  in  DATA_WIDTH  word from the arbiter.
- in_ctrl  in  CTRL_WIDTH  ctrl from the arbiter.
- in_wr  in  1  word valid.
- in_rdy  out  1  upstream may write next cycle.
- out_data  out  DATA_WIDTH  registered word.
- out_ctrl  out  CTRL_WIDTH  registered ctrl.
- out_wr  out  1  registered write strobe.
- out_rdy  in  1  downstream can accept.
- pkt_count  out  32  packets forwarded since reset.
- drop_count  out  32  packets given an empty destination since reset.

Function
REQ-006 Input words SHALL enter a 4-deep FIFO; in_rdy = !nearly_full; a write while full SHALL be ignored (upstream error, not recovered).
REQ-007 A word SHALL be read only when FIFO not empty and out_rdy=1; it appears on out_* exactly 1 cycle after the read, out_wr=1 for that cycle only.
REQ-008 FSM states SHALL be MOD_HDRS (module-header words, ctrl!=0), IN_PACKET (payload words), reset state MOD_HDRS.
REQ-009 MOD_HDRS: word with ctrl==IOQ_STAGE_NUM SHALL be output with data[63:48] replaced by the computed destination, all other bits unchanged; other nonzero-ctrl words pass unmodified; first ctrl==0 word passes and moves FSM to IN_PACKET.
REQ-010 IN_PACKET: words pass unmodified; a word with ctrl!=0 is the last word (eop), passes, increments pkt_count, returns FSM to MOD_HDRS.
REQ-011 Destination from src_port = IOQ header data[31:16]: even src_port <8 -> all MAC bits (16'h0055) with bit src_port cleared; odd src_port <8 -> only bit src_port-1; src_port >=8 -> 16'h0000.
REQ-012 A computed destination of 0 SHALL increment drop_count at that header word; the packet still passes (downstream discards).
REQ-013 Packet lacking an IOQ header SHALL pass unmodified and count in pkt_count only.
REQ-014 Counters SHALL wrap 32'hFFFFFFFF -> 0 without saturation.
REQ-015 out_rdy deasserted mid-packet SHALL stall reads with no word lost or duplicated; FSM state holds.
REQ-016 Single-word packets are not supported (every packet has >=1 header and >=1 ctrl==0 word).

Reset
REQ-017 On reset: FSM=MOD_HDRS, FIFO empty, out_wr=0, out_ctrl=0, out_data=0, pkt_count=0, drop_count=0, in_rdy=1 the cycle after reset deasserts.
REQ-018 Reset mid-packet SHALL discard the partial packet; the next accepted word is treated as a module header.

Structure
REQ-019 Shared package/defines SHALL hold IOQ_STAGE_NUM, header bit positions (dst 63:48, word_len 47:32, src 31:16, byte_len 15:0) and MAC mask 16'h0055.
REQ-020 The input buffer SHALL be an instance of the existing small_fifo (WIDTH=DATA_WIDTH+CTRL_WIDTH, MAX_DEPTH_BITS=2); no other sub-module.

Verification
REQ-021 Header ctrl=FF src=0x0002, 1 ctrl=0 word, eop ctrl=0x80 -> dst field 0x0051, 3 out_wr pulses, pkt_count=1.
REQ-022 src=0x0003 -> dst 0x0004; src=0x0009 -> dst 0x0000, drop_count=1, packet still output.
REQ-023 out_rdy=0 for 5 cycles mid-packet, in_wr held -> in_rdy falls at nearly_full, output sequence identical to no-stall case.
REQ-024 Two back-to-back packets with extra ctrl=0x40 header before IOQ header -> 0x40 word unmodified, both IOQ headers rewritten, pkt_count=2.
REQ-025 Reset asserted on 2nd payload word -> outputs zero next cycle; following clean packet forwarded correctly.
REQ-026 pkt_count preloaded/forced to 0xFFFFFFFF, one packet -> pkt_count=0.
